// File: rtl/aes_round_sched_pkg.sv
// Shared AES job types and round-count constants.
// Used by the round sequencer and its neighbours.
package aes_round_sched_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;

  localparam int AES_NR     = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

endpackage

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: whitening, NR round
// requests to the shared round unit, result handshake.
module aes_round_sched
  import aes_round_sched_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  job_t              in_type,
  input  logic              flush,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      key_in,
  output logic              rnd_valid,
  output logic [127:0]      rnd_state,
  output job_t              rnd_type,
  output logic              rnd_last,
  output logic [127:0]      rnd_key,
  input  logic              rnd_out_valid,
  input  logic [127:0]      rnd_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output job_t              out_type,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    WHITEN,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [KIDX_W-1:0] NRK = KIDX_W'(NR);

  state_t            state;
  state_t            nxt;
  logic [127:0]      state_r;
  job_t              type_r;
  logic [KIDX_W-1:0] rnd_cnt;
  logic              err_r;
  logic              enc;
  logic              last;
  logic              take;
  logic              drop;

  assign enc  = (type_r == ENCRYPT);
  assign last = (rnd_cnt == NRK);
  assign take = (state == IDLE) && in_valid &&
                ((in_type == ENCRYPT) ||
                 (in_type == DECRYPT));
  assign drop = (state == IDLE) && in_valid && !take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (take) nxt = WHITEN;
      WHITEN:  nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT: begin
        if (rnd_out_valid) begin
          nxt = last ? DONE : ISSUE;
        end
      end
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over any completing handshake
    if (flush && (state != IDLE)) begin
      nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= '0;
      type_r  <= INVALID;
      rnd_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      err_r <= drop;
      if (take) begin
        state_r <= in_data;
        type_r  <= in_type;
      end
      if (state == WHITEN) begin
        state_r <= state_r ^ key_in;
        rnd_cnt <= KIDX_W'(1);
      end
      if ((state == WAIT) && rnd_out_valid) begin
        state_r <= rnd_out;
        if (!last) begin
          rnd_cnt <= rnd_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    key_idx   = '0;
    rnd_valid = 1'b0;
    rnd_state = '0;
    rnd_type  = INVALID;
    rnd_last  = 1'b0;
    rnd_key   = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_type  = INVALID;
    unique case (state)
      WHITEN: key_idx = enc ? '0 : NRK;
      ISSUE: begin
        key_idx   = enc ? rnd_cnt : NRK - rnd_cnt;
        rnd_valid = 1'b1;
        rnd_state = state_r;
        rnd_type  = type_r;
        rnd_last  = last;
        rnd_key   = key_in;
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = state_r;
        out_type  = type_r;
      end
      default: ;
    endcase
  end

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state != IDLE);
  assign err      = err_r;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES-128 round unit and key
// store models, FIPS-197 vectors and random blocks.
module tb_aes_round_sched;
  import aes_round_sched_pkg::*;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  job_t         in_type;
  logic         flush;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         rnd_valid;
  logic [127:0] rnd_state;
  job_t         rnd_type;
  logic         rnd_last;
  logic [127:0] rnd_key;
  logic         rnd_out_valid = 1'b0;
  logic [127:0] rnd_out = '0;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  job_t         out_type;
  logic         busy;
  logic         err;

  aes_round_sched #(.NR(NR), .KIDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_type(in_type),
    .flush(flush),
    .key_idx(key_idx), .key_in(key_in),
    .rnd_valid(rnd_valid), .rnd_state(rnd_state),
    .rnd_type(rnd_type), .rnd_last(rnd_last),
    .rnd_key(rnd_key),
    .rnd_out_valid(rnd_out_valid), .rnd_out(rnd_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_type(out_type),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- AES-128 reference ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x,
                                      input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gm(inv, 8'(v));
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
          rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[v]  = s;
      isbox[s] = 8'(v);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]],
             sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++)
      rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // state byte r+4c sits at bits [127-8*(r+4c) -: 8]
  function automatic logic [127:0] sub_shift(
    input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   b;
    int           src;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? r + 4 * ((c + 4 - r) % 4)
                  : r + 4 * ((c + r) % 4);
        b = s[127-8*src -: 8];
        o[127-8*(r+4*c) -: 8] = inv ? isbox[b] : sbox[b];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix(
    input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(m[(j - i + 4) % 4],
                         s[127-8*(j+4*c) -: 8]);
        o[127-8*(i+4*c) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(
    input logic [127:0] s, input logic [127:0] k,
    input bit last);
    logic [127:0] t;
    t = sub_shift(s, 1'b0);
    if (!last) t = mix(t, 1'b0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(
    input logic [127:0] s, input logic [127:0] k,
    input bit last);
    logic [127:0] t;
    t = sub_shift(s, 1'b1) ^ k;
    if (!last) t = mix(t, 1'b1);
    return t;
  endfunction

  function automatic logic [127:0] aes_enc(
    input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r <= NR; r++)
      s = enc_round(s, rk[r], r == NR);
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(
    input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = 1; r <= NR; r++)
      s = dec_round(s, rk[NR-r], r == NR);
    return s;
  endfunction

  // ---------------- key store and round unit ----------------
  assign key_in = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  int           stall_round = 0;
  int           stall_extra = 0;
  int           spur_round  = 0;
  int           md          = 0;
  int           mrnum       = 0;
  bit           mpend       = 1'b0;
  bit           mspur       = 1'b0;
  logic [127:0] mres        = '0;

  always @(posedge clk) begin
    rnd_out_valid <= 1'b0;
    if (mspur) begin
      rnd_out_valid <= 1'b1;
      rnd_out       <= 128'hdead_beef_0bad_f00d_1234_5678_9abc_def0;
      mspur = 1'b0;
    end
    if (rnd_valid) begin
      mrnum = (rnd_type == ENCRYPT) ? int'(key_idx)
                                    : NR - int'(key_idx);
      mres  = (rnd_type == ENCRYPT)
              ? enc_round(rnd_state, rnd_key, rnd_last)
              : dec_round(rnd_state, rnd_key, rnd_last);
      md    = (mrnum == stall_round) ? stall_extra : 0;
      mpend = 1'b1;
    end else if (mpend) begin
      md = md - 1;
    end
    if (mpend && md == 0) begin
      rnd_out_valid <= 1'b1;
      rnd_out       <= mres;
      mpend = 1'b0;
      if (mrnum + 1 == spur_round) mspur = 1'b1;
    end
  end

  // ---------------- observation ----------------
  logic [3:0] idx_q  [$];
  bit         last_q [$];
  int         dbl_rv  = 0;
  int         ov_rise = 0;
  int         err_cnt = 0;
  bit         prev_rv = 1'b0;
  bit         prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rnd_valid) begin
        idx_q.push_back(key_idx);
        last_q.push_back(rnd_last);
      end
      if (rnd_valid && prev_rv) dbl_rv++;
      if (out_valid && !prev_ov) ov_rise++;
      if (err) err_cnt++;
      prev_rv = rnd_valid;
      prev_ov = out_valid;
    end
  end

  // ---------------- checking helpers ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [127:0] d,
                           input job_t t);
    chk("in_ready at offer", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_type  = t;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [127:0] d,
                         input job_t t,
                         input int hold,
                         output logic [127:0] res,
                         output job_t rt,
                         output int cyc,
                         output logic [3:0] wk);
    start_job(d, t);
    cyc = 1;
    wk  = key_idx;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk("out_valid timeout", 128'(0), 128'(1));
    res = out_data;
    rt  = out_type;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold out_valid", 128'(out_valid), 128'(1));
      chk("hold out_data", out_data, res);
      chk("hold out_type", 128'(out_type), 128'(rt));
      chk("hold in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int s,
                         input bit dec);
    logic [63:0] got;
    logic [63:0] exp;
    logic [15:0] gl;
    logic [15:0] el;
    int          n;
    got = '0; exp = '0; gl = '0; el = '0;
    n = idx_q.size() - s;
    chk({tag, " nreq"}, 128'(n), 128'(NR));
    for (int i = 0; i < NR && i < n; i++) begin
      got   = (got << 4) | 64'(idx_q[s+i]);
      exp   = (exp << 4) | 64'(dec ? NR - 1 - i : i + 1);
      gl[i] = last_q[s+i];
      el[i] = (i == NR - 1);
    end
    chk({tag, " key_idx seq"}, 128'(got), 128'(exp));
    chk({tag, " rnd_last seq"}, 128'(gl), 128'(el));
  endtask

  task automatic wait_round(input int idx);
    int k;
    k = 0;
    while (!(rnd_valid && key_idx == 4'(idx)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("wait round timeout", 128'(0), 128'(1));
  endtask

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] res;
    logic [127:0] x;
    job_t         rt;
    int           cyc;
    int           s;
    int           snap_ov;
    int           snap_err;
    logic [3:0]   wk;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    in_type = INVALID; flush = 1'b0; out_ready = 1'b0;
    build_tables();
    expand_key(KEY);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst in_ready", 128'(in_ready), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst rnd_valid", 128'(rnd_valid), 128'(0));
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst err", 128'(err), 128'(0));
    chk("rst key_idx", 128'(key_idx), 128'(0));
    chk("rst out_data", out_data, 128'(0));
    chk("rst rnd_key", rnd_key, 128'(0));
    chk("rst out_type", 128'(out_type), 128'(INVALID));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", 128'(in_ready), 128'(1));

    // model self-consistency against FIPS-197 C.1
    chk("model enc C.1", aes_enc(PT), CT);
    chk("model dec C.1", aes_dec(CT), PT);

    // C.1 encrypt, with a 5-cycle stalled consumer
    s = idx_q.size();
    run_job(PT, ENCRYPT, 5, res, rt, cyc, wk);
    chk("C1 enc data", res, CT);
    chk("C1 enc type", 128'(rt), 128'(ENCRYPT));
    chk("C1 enc latency", 128'(cyc), 128'(2 * NR + 2));
    chk("C1 enc whiten idx", 128'(wk), 128'(0));
    chk_seq("C1 enc", s, 1'b0);

    // C.1 decrypt, back-to-back after the first handshake
    s = idx_q.size();
    run_job(CT, DECRYPT, 0, res, rt, cyc, wk);
    chk("C1 dec data", res, PT);
    chk("C1 dec type", 128'(rt), 128'(DECRYPT));
    chk("C1 dec latency", 128'(cyc), 128'(2 * NR + 2));
    chk("C1 dec whiten idx", 128'(wk), 128'(NR));
    chk_seq("C1 dec", s, 1'b1);

    // round 4 result delayed 3 extra cycles
    stall_round = 4; stall_extra = 3;
    x = {$urandom, $urandom, $urandom, $urandom};
    run_job(x, ENCRYPT, 0, res, rt, cyc, wk);
    chk("stall data", res, aes_enc(x));
    chk("stall latency", 128'(cyc), 128'(2 * NR + 5));
    stall_round = 0; stall_extra = 0;

    // spurious rnd_out_valid while round 5 is being issued
    spur_round = 5;
    x = {$urandom, $urandom, $urandom, $urandom};
    run_job(x, DECRYPT, 0, res, rt, cyc, wk);
    chk("spur data", res, aes_dec(x));
    chk("spur latency", 128'(cyc), 128'(2 * NR + 2));
    spur_round = 0;

    // INVALID job is accepted and dropped
    snap_ov = ov_rise; snap_err = err_cnt; s = idx_q.size();
    chk("inv in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_type = INVALID; in_data = PT;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("inv err pulse", 128'(err), 128'(1));
    chk("inv busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("inv err end", 128'(err), 128'(0));
    repeat (4) @(negedge clk);
    chk("inv err count", 128'(err_cnt - snap_err), 128'(1));
    chk("inv no rnd", 128'(idx_q.size() - s), 128'(0));
    chk("inv no out", 128'(ov_rise - snap_ov), 128'(0));

    // flush during round 6
    snap_ov = ov_rise; snap_err = err_cnt;
    start_job({$urandom, $urandom, $urandom, $urandom}, ENCRYPT);
    wait_round(6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 128'(busy), 128'(0));
    chk("flush out_valid", 128'(out_valid), 128'(0));
    chk("flush in_ready", 128'(in_ready), 128'(1));
    repeat (5) @(negedge clk);
    chk("flush no out", 128'(ov_rise - snap_ov), 128'(0));
    chk("flush no err", 128'(err_cnt - snap_err), 128'(0));
    x = {$urandom, $urandom, $urandom, $urandom};
    run_job(x, ENCRYPT, 0, res, rt, cyc, wk);
    chk("post-flush data", res, aes_enc(x));

    // asynchronous reset during round 3
    start_job(PT, ENCRYPT);
    wait_round(3);
    rst_n = 1'b0;
    #1;
    chk("mid-rst in_ready", 128'(in_ready), 128'(0));
    chk("mid-rst busy", 128'(busy), 128'(0));
    chk("mid-rst rnd_valid", 128'(rnd_valid), 128'(0));
    chk("mid-rst rnd_state", rnd_state, 128'(0));
    chk("mid-rst key_idx", 128'(key_idx), 128'(0));
    chk("mid-rst rnd_type", 128'(rnd_type), 128'(INVALID));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = idx_q.size();
    run_job(PT, ENCRYPT, 0, res, rt, cyc, wk);
    chk("post-rst C1 data", res, CT);
    chk("post-rst C1 latency", 128'(cyc), 128'(2 * NR + 2));
    chk_seq("post-rst C1", s, 1'b0);

    // random back-to-back jobs against the reference
    for (int j = 0; j < 6; j++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      if (j % 2 == 0) begin
        run_job(x, ENCRYPT, $urandom_range(0, 2),
                res, rt, cyc, wk);
        chk("rand enc data", res, aes_enc(x));
        chk("rand enc type", 128'(rt), 128'(ENCRYPT));
      end else begin
        run_job(x, DECRYPT, $urandom_range(0, 2),
                res, rt, cyc, wk);
        chk("rand dec data", res, aes_dec(x));
        chk("rand dec type", 128'(rt), 128'(DECRYPT));
      end
    end

    chk("rnd_valid single-cycle", 128'(dbl_rv), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
- Iterative sequencer for the shared single-round AES datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, encrypt and decrypt paths, registered output).
- Accepts one 128-bit block plus job type over a valid/ready handshake and performs the initial AddRoundKey (whitening) itself.
- Issues NR round requests to the round unit, fetching round-key indices from the key store in forward (encrypt) or reverse (decrypt) order.
- Returns the finished block over a valid/ready output handshake. Sits between the job front-end and the round datapath.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256)
- KIDX_W, 4, width of the round-key index; must satisfy 2**KIDX_W > NR

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  scheduler can accept; high only in IDLE
- in_data  in  128  plaintext/ciphertext block
- in_type  in  job_t  ENCRYPT / DECRYPT / INVALID
- flush  in  1  synchronous abort of the current job
- key_idx  out  KIDX_W  round-key index to the key store (combinational read)
- key_in  in  128  round key for key_idx, same cycle
- rnd_valid  out  1  round request strobe
- rnd_state  out  128  state to round unit
- rnd_type  out  job_t  job type to round unit
- rnd_last  out  1  final round (round unit skips (Inv)MixColumns)
- rnd_key  out  128  round key forwarded to round unit (= key_in)
- rnd_out_valid  in  1  round result valid
- rnd_out  in  128  round result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  128  result block
- out_type  out  job_t  type of the result
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse when an INVALID job is dropped

Behaviour:
- Reset values: in_ready=0 while rst_n is low, and 1 after reset (IDLE). rnd_valid=0, rnd_last=0, out_valid=0, err=0, busy=0. out_data, rnd_state and rnd_key are 0. out_type and rnd_type are INVALID. key_idx=0. The round counter resets to 0.
- FSM states: IDLE, WHITEN, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid with in_type ENCRYPT/DECRYPT, latch data and type, then go to WHITEN.
  - On in_valid with in_type INVALID, the job is accepted and dropped: pulse err next cycle, stay in IDLE.
- WHITEN:
  - key_idx = 0 (ENC) or NR (DEC).
  - state_r <= data ^ key_in; rnd_cnt <= 1; go to ISSUE.
- ISSUE:
  - rnd_valid=1 for exactly one cycle.
  - rnd_state=state_r and rnd_type=latched type.
  - key_idx = rnd_cnt (ENC) or NR-rnd_cnt (DEC).
  - rnd_last = (rnd_cnt==NR).
  - Go to WAIT.
- WAIT:
  - Hold until rnd_out_valid; an arbitrary number of stall cycles is allowed.
  - On rnd_out_valid: state_r <= rnd_out.
  - If rnd_cnt==NR, go to DONE; otherwise rnd_cnt++ and go to ISSUE.
  - rnd_out_valid outside WAIT is ignored.
- DONE:
  - out_valid=1, out_data=state_r, out_type=latched type.
  - These values are held stable until out_ready; on out_ready go to IDLE.
  - in_ready stays 0, so there is no overlap between jobs.
- Latency: with the round unit's nominal 1-cycle latency, accept at cycle 0 gives out_valid at cycle 2*NR+2 (22 for NR=10). Throughput is one job per 2*NR+3 cycles.
- flush: in any non-IDLE state, go to IDLE next cycle. out_valid drops, no output is produced, and no err pulse is generated. Flush in IDLE has no effect. Flush has priority over simultaneous rnd_out_valid or out_ready.
- Asynchronous reset mid-job discards the job; all outputs return to their reset values immediately.
- rnd_key is driven from key_in combinationally; it is only meaningful while rnd_valid is high.
- rnd_cnt is KIDX_W bits wide and never exceeds NR (no wrap).

Decomposition:
- job_t (INVALID/ENCRYPT/DECRYPT) and AES_NR constants live in the shared system package; nothing is redefined locally.
- The FSM state enum is local to the module.
- No sub-module: the whitening XOR, counter and FSM form one module. An optional round-key index helper function (rnd_cnt, type → key_idx) may sit in the package.

Test Plan:
- FIPS-197 C.1, with the real round unit and a key-store model: key 000102…0f, ENCRYPT 00112233445566778899aabbccddeeff → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly at cycle 22, key_idx sequence 0,1,…,10.
- DECRYPT 69c4e0d86a7b0430d8cdb78070b4c55a with the same key store → 00112233445566778899aabbccddeeff, key_idx sequence 10,9,…,0, rnd_last only on the 10th request.
- out_ready held low for 5 cycles in DONE → out_data/out_type stable, in_ready=0. Then two back-to-back jobs → second accepted the cycle after the first handshake.
- rnd_out_valid delayed by 3 cycles on round 4 → result still correct and out_valid at cycle 25. A spurious rnd_out_valid in ISSUE is ignored.
- INVALID job → accepted (in_ready=1), err pulses 1 cycle, no rnd_valid and no out_valid. flush asserted during round 6 → busy=0 next cycle, no output, next job correct.
- rst_n asserted low during round 3 → all outputs at reset values immediately. After release, a fresh job returns the C.1 ciphertext.
